// File: rtl/kv_request_sequencer.sv
// Command sequencer in front of the cuckoo-hash key/value BRAM store: request FIFO,
// fixed-latency store access, response port. Optional macro KV_STATS_EN adds per-op counters.
module kv_request_sequencer #(
  parameter int RAM_WIDTH      = 32,
  parameter int FIFO_ADDR_BITS = 2,
  parameter int STORE_LATENCY  = 100
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_op,
  input  logic [RAM_WIDTH-1:0] req_key,
  input  logic [RAM_WIDTH-1:0] req_data,
  input  logic                 req_kind,
  output logic                 store_ram_enable,
  output logic                 store_write_enable,
  output logic [1:0]           store_signal,
  output logic [RAM_WIDTH-1:0] store_key,
  output logic [RAM_WIDTH-1:0] store_value,
  output logic [RAM_WIDTH-1:0] store_transact_value,
  output logic                 store_transact_kind,
  input  logic [RAM_WIDTH-1:0] store_updated_value,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [1:0]           rsp_op,
  output logic [RAM_WIDTH-1:0] rsp_key,
  output logic [RAM_WIDTH-1:0] rsp_value,
  output logic                 rsp_err,
`ifdef KV_STATS_EN
  output logic [15:0]          stat_search,
  output logic [15:0]          stat_insert,
  output logic [15:0]          stat_transact,
`endif
  output logic                 busy
);

  localparam int DEPTH = 1 << FIFO_ADDR_BITS;
  localparam int CNT_W = (STORE_LATENCY > 2) ? $clog2(STORE_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t state, state_next;

  logic [1:0]           fifo_op   [DEPTH];
  logic [RAM_WIDTH-1:0] fifo_key  [DEPTH];
  logic [RAM_WIDTH-1:0] fifo_data [DEPTH];
  logic                 fifo_kind [DEPTH];

  logic [FIFO_ADDR_BITS-1:0] wr_ptr, rd_ptr;
  logic [FIFO_ADDR_BITS:0]   count;
  logic                      fifo_full, push, pop;
  logic [1:0]                head_op;

  logic [1:0]           cmd_op;
  logic [RAM_WIDTH-1:0] cmd_key;
  logic [CNT_W-1:0]     cnt;

  assign fifo_full          = (count == (FIFO_ADDR_BITS+1)'(DEPTH));
  assign req_ready          = !fifo_full;
  assign push               = req_valid && req_ready;
  assign head_op            = fifo_op[rd_ptr];
  assign busy               = (state != IDLE) || (count != '0);
  assign store_write_enable = 1'b0;

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          state_next = (head_op == 2'd3) ? RESP : ISSUE;
        end else begin
          state_next = IDLE;
        end
      end
      ISSUE: state_next = WAIT;
      WAIT: begin
        if (cnt == '0) state_next = RESP;
        else           state_next = WAIT;
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
        else           state_next = RESP;
      end
      default: state_next = IDLE;
    endcase
  end

  // Storage array carries no reset; only pointers/occupancy define validity.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_op[wr_ptr]   <= req_op;
      fifo_key[wr_ptr]  <= req_key;
      fifo_data[wr_ptr] <= req_data;
      fifo_kind[wr_ptr] <= req_kind;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{FIFO_ADDR_BITS{1'b0}}, push} - {{FIFO_ADDR_BITS{1'b0}}, pop};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Store inputs are loaded on the pop edge so they are stable for the whole
  // ISSUE+WAIT window, i.e. STORE_LATENCY cycles up to the sampling edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      store_ram_enable     <= 1'b1;
      store_signal         <= 2'd3;
      store_key            <= '0;
      store_value          <= '0;
      store_transact_value <= '0;
      store_transact_kind  <= 1'b0;
      cmd_op               <= 2'd0;
      cmd_key              <= '0;
      cnt                  <= '0;
      rsp_valid            <= 1'b0;
      rsp_op               <= 2'd0;
      rsp_key              <= '0;
      rsp_value            <= '0;
      rsp_err              <= 1'b0;
    end else begin
      store_ram_enable <= 1'b1;
      case (state)
        IDLE: begin
          if (pop) begin
            cmd_op  <= head_op;
            cmd_key <= fifo_key[rd_ptr];
            if (head_op == 2'd3) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_value <= '0;
              rsp_op    <= head_op;
              rsp_key   <= fifo_key[rd_ptr];
            end else begin
              store_signal <= head_op;
              store_key    <= fifo_key[rd_ptr];
              if (head_op == 2'd1) store_value <= fifo_data[rd_ptr];
              if (head_op == 2'd2) begin
                store_transact_value <= fifo_data[rd_ptr];
                store_transact_kind  <= fifo_kind[rd_ptr];
              end
            end
          end
        end
        ISSUE: cnt <= CNT_W'(STORE_LATENCY - 2);
        WAIT: begin
          if (cnt == '0) begin
            rsp_valid    <= 1'b1;
            rsp_err      <= 1'b0;
            rsp_value    <= store_updated_value;
            rsp_op       <= cmd_op;
            rsp_key      <= cmd_key;
            store_signal <= 2'd3;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: rsp_valid <= 1'b0;
      endcase
    end
  end

`ifdef KV_STATS_EN
  logic rsp_fire;
  assign rsp_fire = (state == RESP) && rsp_valid && rsp_ready;

  // Saturating per-op response counters; op 3 is not counted.
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_search   <= 16'd0;
      stat_insert   <= 16'd0;
      stat_transact <= 16'd0;
    end else if (rsp_fire) begin
      case (rsp_op)
        2'd0: if (stat_search   != 16'hFFFF) stat_search   <= stat_search   + 16'd1;
        2'd1: if (stat_insert   != 16'hFFFF) stat_insert   <= stat_insert   + 16'd1;
        2'd2: if (stat_transact != 16'hFFFF) stat_transact <= stat_transact + 16'd1;
        default: stat_search <= stat_search;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_kv_request_sequencer.sv
// Directed self-checking bench for kv_request_sequencer with a behavioural store model.
module tb_kv_request_sequencer;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         req_valid, req_ready, req_kind;
  logic [1:0]   req_op;
  logic [W-1:0] req_key, req_data;
  logic         store_ram_enable, store_write_enable, store_transact_kind;
  logic [1:0]   store_signal;
  logic [W-1:0] store_key, store_value, store_transact_value, store_updated_value;
  logic         rsp_valid, rsp_ready, rsp_err, busy;
  logic [1:0]   rsp_op;
  logic [W-1:0] rsp_key, rsp_value;
`ifdef KV_STATS_EN
  logic [15:0]  stat_search, stat_insert, stat_transact;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  kv_request_sequencer dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_key(req_key), .req_data(req_data), .req_kind(req_kind),
    .store_ram_enable(store_ram_enable), .store_write_enable(store_write_enable),
    .store_signal(store_signal), .store_key(store_key), .store_value(store_value),
    .store_transact_value(store_transact_value), .store_transact_kind(store_transact_kind),
    .store_updated_value(store_updated_value),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op),
    .rsp_key(rsp_key), .rsp_value(rsp_value), .rsp_err(rsp_err),
`ifdef KV_STATS_EN
    .stat_search(stat_search), .stat_insert(stat_insert), .stat_transact(stat_transact),
`endif
    .busy(busy)
  );

  // Store model: every account balance is 500, search returns key+1000.
  always_comb begin
    case (store_signal)
      2'd0:    store_updated_value = store_key + 32'd1000;
      2'd1:    store_updated_value = store_value;
      2'd2:    store_updated_value = store_transact_kind ? 32'd500 + store_transact_value
                                                         : 32'd500 - store_transact_value;
      default: store_updated_value = 32'd0;
    endcase
  end

  int match1_cnt = 0;
  int issue_cnt  = 0;
  logic [1:0] prev_sig = 2'd3;
  always @(negedge clock) begin
    if (store_signal == 2'd1 && store_key == 32'd279 && store_value == 32'd7623)
      match1_cnt++;
    if (prev_sig == 2'd3 && store_signal != 2'd3) issue_cnt++;
    prev_sig = store_signal;
  end

  logic [W-1:0] q_value[$];
  logic [W-1:0] q_key[$];
  logic [1:0]   q_op[$];
  logic         q_err[$];
  always @(posedge clock) begin
    if (!reset && rsp_valid && rsp_ready) begin
      q_value.push_back(rsp_value);
      q_key.push_back(rsp_key);
      q_op.push_back(rsp_op);
      q_err.push_back(rsp_err);
    end
  end

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_req(input logic [1:0] op, input logic [W-1:0] key,
                          input logic [W-1:0] data, input logic kind);
    int n = 0;
    @(negedge clock);
    req_valid = 1'b1; req_op = op; req_key = key; req_data = data; req_kind = kind;
    while (!req_ready && n < 2000) begin
      @(negedge clock);
      n++;
    end
    if (!req_ready) begin
      check_value("push_timeout", 64'(req_ready), 64'd1);
      req_valid = 1'b0;
    end else begin
      @(posedge clock);
      #1 req_valid = 1'b0;
    end
  endtask

  task automatic wait_rsp();
    int n = 0;
    @(negedge clock);
    while (!rsp_valid && n < 500) begin
      @(negedge clock);
      n++;
    end
    if (!rsp_valid) check_value("rsp_timeout", 64'(rsp_valid), 64'd1);
  endtask

  task automatic ack_rsp();
    @(negedge clock); rsp_ready = 1'b1;
    @(negedge clock); rsp_ready = 1'b0;
  endtask

  task automatic wait_q(input int target);
    int n = 0;
    while (q_value.size() < target && n < 2000) begin
      @(negedge clock);
      n++;
    end
    check_value("queue_fill", 64'(q_value.size()), 64'(target));
  endtask

  int base, m1, iss;
  logic [W-1:0] exp_val [5] = '{32'd111, 32'd1022, 32'd450, 32'd444, 32'd0};
  logic [W-1:0] exp_key [5] = '{32'd11, 32'd22, 32'd33, 32'd44, 32'd55};
  logic [1:0]   exp_op  [5] = '{2'd1, 2'd0, 2'd2, 2'd1, 2'd3};

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = 2'd0; req_key = '0; req_data = '0;
    req_kind = 1'b0; rsp_ready = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_value("rst_signal", 64'(store_signal), 64'd3);
    check_value("rst_ram_en", 64'(store_ram_enable), 64'd1);
    check_value("rst_wr_en", 64'(store_write_enable), 64'd0);
    check_value("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check_value("rst_req_ready", 64'(req_ready), 64'd1);
    check_value("rst_busy", 64'(busy), 64'd0);
    check_value("rst_rsp_key", 64'(rsp_key), 64'd0);

    // 1: single insert, store held exactly 100 cycles
    m1 = match1_cnt;
    push_req(2'd1, 32'd279, 32'd7623, 1'b0);
    wait_rsp();
    check_value("t1_hold_cycles", 64'(match1_cnt - m1), 64'd100);
    check_value("t1_signal_idle", 64'(store_signal), 64'd3);
    check_value("t1_op", 64'(rsp_op), 64'd1);
    check_value("t1_key", 64'(rsp_key), 64'd279);
    check_value("t1_value", 64'(rsp_value), 64'd7623);
    check_value("t1_err", 64'(rsp_err), 64'd0);
    ack_rsp();
    check_value("t1_rsp_cleared", 64'(rsp_valid), 64'd0);

    // 2: back-to-back inserts with rsp_ready high
    base = q_value.size(); iss = issue_cnt;
    rsp_ready = 1'b1;
    push_req(2'd1, 32'd279, 32'd7623, 1'b0);
    push_req(2'd1, 32'd524, 32'd3423, 1'b0);
    wait_q(base + 2);
    if (q_value.size() >= base + 2) begin
      check_value("t2_value0", 64'(q_value[base]), 64'd7623);
      check_value("t2_value1", 64'(q_value[base+1]), 64'd3423);
      check_value("t2_key1", 64'(q_key[base+1]), 64'd524);
    end
    check_value("t2_issues", 64'(issue_cnt - iss), 64'd2);
    @(negedge clock); rsp_ready = 1'b0;

    // 3: five requests with response stalled, then drain in order
    base = q_value.size();
    push_req(2'd1, 32'd11, 32'd111, 1'b0);
    push_req(2'd0, 32'd22, 32'd0, 1'b0);
    push_req(2'd2, 32'd33, 32'd50, 1'b0);
    push_req(2'd1, 32'd44, 32'd444, 1'b0);
    push_req(2'd3, 32'd55, 32'd9, 1'b0);
    @(negedge clock);
    check_value("t3_full_ready", 64'(req_ready), 64'd0);
    check_value("t3_busy", 64'(busy), 64'd1);
    rsp_ready = 1'b1;
    wait_q(base + 5);
    if (q_value.size() >= base + 5) begin
      for (int i = 0; i < 5; i++) begin
        check_value($sformatf("t3_value%0d", i), 64'(q_value[base+i]), 64'(exp_val[i]));
        check_value($sformatf("t3_key%0d", i), 64'(q_key[base+i]), 64'(exp_key[i]));
        check_value($sformatf("t3_op%0d", i), 64'(q_op[base+i]), 64'(exp_op[i]));
        check_value($sformatf("t3_err%0d", i), 64'(q_err[base+i]), (i == 4) ? 64'd1 : 64'd0);
      end
    end
    @(negedge clock); rsp_ready = 1'b0;
    repeat (2) @(negedge clock);
    check_value("t3_idle", 64'(busy), 64'd0);

    // 4: transact add
    push_req(2'd2, 32'd249, 32'd100, 1'b1);
    repeat (3) @(negedge clock);
    check_value("t4_signal", 64'(store_signal), 64'd2);
    check_value("t4_key", 64'(store_key), 64'd249);
    check_value("t4_tvalue", 64'(store_transact_value), 64'd100);
    check_value("t4_tkind", 64'(store_transact_kind), 64'd1);
    wait_rsp();
    check_value("t4_value", 64'(rsp_value), 64'd600);
    check_value("t4_op", 64'(rsp_op), 64'd2);
    ack_rsp();

    // 5: invalid op responds one cycle after pop, store untouched
    iss = issue_cnt;
    push_req(2'd3, 32'd7, 32'd5, 1'b0);
    @(negedge clock);
    check_value("t5_not_yet", 64'(rsp_valid), 64'd0);
    @(negedge clock);
    check_value("t5_valid", 64'(rsp_valid), 64'd1);
    check_value("t5_err", 64'(rsp_err), 64'd1);
    check_value("t5_value", 64'(rsp_value), 64'd0);
    check_value("t5_key", 64'(rsp_key), 64'd7);
    check_value("t5_signal", 64'(store_signal), 64'd3);
    ack_rsp();
    check_value("t5_no_issue", 64'(issue_cnt - iss), 64'd0);

    // 6: reset 40 cycles into WAIT with two queued
    push_req(2'd1, 32'd71, 32'd1, 1'b0);
    push_req(2'd1, 32'd72, 32'd2, 1'b0);
    push_req(2'd1, 32'd73, 32'd3, 1'b0);
    repeat (40) @(negedge clock);
    check_value("t6_in_wait", 64'(store_signal), 64'd1);
    reset = 1'b1;
    @(negedge clock);
    check_value("t6_signal", 64'(store_signal), 64'd3);
    check_value("t6_rsp_valid", 64'(rsp_valid), 64'd0);
    check_value("t6_req_ready", 64'(req_ready), 64'd1);
    reset = 1'b0;
    base = q_value.size(); iss = issue_cnt;
    rsp_ready = 1'b1;
    repeat (300) @(negedge clock);
    check_value("t6_no_rsp", 64'(q_value.size() - base), 64'd0);
    check_value("t6_no_issue", 64'(issue_cnt - iss), 64'd0);
    check_value("t6_busy", 64'(busy), 64'd0);
`ifdef KV_STATS_EN
    check_value("t6_stat_insert", 64'(stat_insert), 64'd0);
    check_value("t6_stat_search", 64'(stat_search), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
